alu_sequencer: RTL and testbench

//  Microcode sequencer in front of the 4-bit ALU unit (instr/bus interface).

---
 rtl/alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: microcode sequencer that sits in front of a 4-bit ALU.
// It accepts one macro-op per request handshake and expands it into ALU
// instruction steps. During operand steps it drives the shared bus. It
// captures the result and flags that the ALU places on the bus, and it
// returns them on a response handshake port.
module alu_sequencer #(
    parameter int DATA_W  = 4,
    parameter int INSTR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    input  logic [DATA_W-1:0]  req_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic [DATA_W-1:0]  rsp_flags,
    output logic               rsp_err,
    output logic               busy,
    output logic [INSTR_W-1:0] alu_instr,
    inout  wire  [DATA_W-1:0]  bus
);

    // Macro-op encodings
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LOGIC = 3'd2;
    localparam logic [2:0] OP_ACC   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    // ALU instruction encodings
    localparam logic [INSTR_W-1:0] I_NOP    = INSTR_W'(4'h0);
    localparam logic [INSTR_W-1:0] I_BUS_X1 = INSTR_W'(4'h1);
    localparam logic [INSTR_W-1:0] I_BUS_X2 = INSTR_W'(4'h2);
    localparam logic [INSTR_W-1:0] I_BUS_X3 = INSTR_W'(4'h3);
    localparam logic [INSTR_W-1:0] I_LOGIC  = INSTR_W'(4'h4);
    localparam logic [INSTR_W-1:0] I_ADD    = INSTR_W'(4'h5);
    localparam logic [INSTR_W-1:0] I_SUB    = INSTR_W'(4'h6);
    localparam logic [INSTR_W-1:0] I_R_BUS  = INSTR_W'(4'h7);
    localparam logic [INSTR_W-1:0] I_F_BUS  = INSTR_W'(4'h8);
    localparam logic [INSTR_W-1:0] I_R_X1   = INSTR_W'(4'h9);
    localparam logic [INSTR_W-1:0] I_CLEAR  = INSTR_W'(4'hF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Microcode ROM: the instruction for step idx of macro-op op.
    // Indices past the end of a sequence return NOP.
    function automatic logic [INSTR_W-1:0] step_code(input logic [2:0] op,
                                                     input logic [2:0] idx);
        logic [INSTR_W-1:0] code;
        code = I_NOP;
        case (op)
            OP_ADD, OP_SUB: begin
                case (idx)
                    3'd0:    code = I_BUS_X1;
                    3'd1:    code = I_BUS_X2;
                    3'd2:    code = (op == OP_ADD) ? I_ADD : I_SUB;
                    3'd3:    code = I_R_BUS;
                    3'd4:    code = I_F_BUS;
                    default: code = I_NOP;
                endcase
            end
            OP_LOGIC: begin
                case (idx)
                    3'd0:    code = I_BUS_X1;
                    3'd1:    code = I_BUS_X2;
                    3'd2:    code = I_BUS_X3;
                    3'd3:    code = I_LOGIC;
                    3'd4:    code = I_R_BUS;
                    3'd5:    code = I_F_BUS;
                    default: code = I_NOP;
                endcase
            end
            OP_ACC: begin
                case (idx)
                    3'd0:    code = I_R_X1;
                    3'd1:    code = I_BUS_X2;
                    3'd2:    code = I_ADD;
                    3'd3:    code = I_R_BUS;
                    3'd4:    code = I_F_BUS;
                    default: code = I_NOP;
                endcase
            end
            OP_CLEAR: code = (idx == 3'd0) ? I_CLEAR : I_NOP;
            default:  code = I_NOP;
        endcase
        return code;
    endfunction

    // Number of ALU steps issued for each macro-op (zero for illegal ops)
    function automatic logic [2:0] num_steps(input logic [2:0] op);
        logic [2:0] n;
        case (op)
            OP_ADD, OP_SUB, OP_ACC: n = 3'd5;
            OP_LOGIC:               n = 3'd6;
            OP_CLEAR:               n = 3'd1;
            default:                n = 3'd0;
        endcase
        return n;
    endfunction

    state_t              state_q;
    logic [2:0]          idx_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q, sel_q;
    logic [INSTR_W-1:0]  alu_instr_q;
    logic                bus_oe_q;
    logic [DATA_W-1:0]   bus_drv_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   result_q, flags_q;
    logic                err_q;
    logic                busy_q;

    logic [2:0]          src_op_s;
    logic [2:0]          src_idx_s;
    logic [DATA_W-1:0]   src_a_s, src_b_s, src_sel_s;
    logic [INSTR_W-1:0]  instr_d;
    logic                oe_d;
    logic [DATA_W-1:0]   drv_d;
    logic                illegal_s;

    // Next step to issue. In IDLE it comes from the incoming request, and
    // otherwise from the latched macro-op. The bus drive follows the step.
    always_comb begin
        src_op_s  = op_q;
        src_idx_s = idx_q;
        src_a_s   = a_q;
        src_b_s   = b_q;
        src_sel_s = sel_q;
        if (state_q == ST_IDLE) begin
            src_op_s  = req_op;
            src_idx_s = 3'd0;
            src_a_s   = req_a;
            src_b_s   = req_b;
            src_sel_s = req_sel;
        end else begin
            src_op_s  = op_q;
            src_idx_s = idx_q;
        end
        instr_d = step_code(src_op_s, src_idx_s);
        case (instr_d)
            I_BUS_X1: begin oe_d = 1'b1; drv_d = src_a_s;   end
            I_BUS_X2: begin oe_d = 1'b1; drv_d = src_b_s;   end
            I_BUS_X3: begin oe_d = 1'b1; drv_d = src_sel_s; end
            default:  begin oe_d = 1'b0; drv_d = '0;        end
        endcase
        illegal_s = (req_op > OP_CLEAR);
    end

    // Sequencer FSM. All outputs, including the instruction and the bus
    // drive, are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            alu_instr_q <= I_NOP;
            bus_oe_q    <= 1'b0;
            bus_drv_q   <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        sel_q       <= req_sel;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        if (illegal_s) begin
                            // No ALU step at all: respond straight away
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            err_q       <= 1'b1;
                            result_q    <= '0;
                            flags_q     <= '0;
                            alu_instr_q <= I_NOP;
                            bus_oe_q    <= 1'b0;
                        end else begin
                            state_q     <= ST_RUN;
                            idx_q       <= 3'd1;
                            alu_instr_q <= instr_d;
                            bus_oe_q    <= oe_d;
                            bus_drv_q   <= drv_d;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                        alu_instr_q <= I_NOP;
                        bus_oe_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The ALU drives R/FLAG during steps 7/8: sample at the closing edge
                    if (alu_instr_q == I_R_BUS) begin
                        result_q <= bus;
                    end
                    if (alu_instr_q == I_F_BUS) begin
                        flags_q <= bus;
                    end
                    if (idx_q == num_steps(op_q)) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        alu_instr_q <= I_NOP;
                        bus_oe_q    <= 1'b0;
                        if (op_q == OP_CLEAR) begin
                            result_q <= '0;
                            flags_q  <= '0;
                        end
                    end else begin
                        idx_q       <= idx_q + 3'd1;
                        alu_instr_q <= instr_d;
                        bus_oe_q    <= oe_d;
                        bus_drv_q   <= drv_d;
                    end
                end
                ST_RESP: begin
                    alu_instr_q <= I_NOP;
                    bus_oe_q    <= 1'b0;
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    alu_instr_q <= I_NOP;
                    bus_oe_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus        = bus_oe_q ? bus_drv_q : {DATA_W{1'bz}};
    assign alu_instr  = alu_instr_q;
    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small behavioural ALU sits on the shared bus.
// Directed macro-ops are issued with hand-computed expected responses
// pushed into a scoreboard. A monitor pops and compares each response.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       rsp_ready = 1'b1;
    logic [2:0] req_op = 3'd0;
    logic [3:0] req_a = 4'h0, req_b = 4'h0, req_sel = 4'h0;
    wire        req_ready, rsp_valid, rsp_err, busy;
    wire  [3:0] rsp_result, rsp_flags, alu_instr;
    wire  [3:0] bus;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] flg;
        logic       err;
    } rsp_t;
    rsp_t exp_q[$];

    // LOGIC results/flags for a=4 b=1, nibble s = sel (1..7)
    logic [31:0] lres_tab = 32'hAAFB5500;
    logic [31:0] lflg_tab = 32'h44440010;

    alu_sequencer #(.DATA_W(4), .INSTR_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .alu_instr(alu_instr), .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural ALU (flags = {0, N, C/borrow, Z}) ----------
    logic [3:0] x1 = 4'h0, x2 = 4'h0, x3 = 4'h0, r = 4'h0, flg = 4'h0;

    function automatic logic [3:0] logic_fn(input logic [3:0] s, input logic [3:0] p, input logic [3:0] q);
        case (s[2:0])
            3'd1:    return p & q;
            3'd2:    return p | q;
            3'd3:    return p ^ q;
            3'd4:    return ~p;
            3'd5:    return ~(p & q);
            3'd6:    return ~(p | q);
            3'd7:    return ~(p ^ q);
            default: return p;
        endcase
    endfunction

    function automatic logic [3:0] mk_flags(input logic [3:0] v, input logic c);
        return {1'b0, v[3], c, (v == 4'h0)};
    endfunction

    wire [4:0] sum5 = {1'b0, x1} + {1'b0, x2};
    wire [4:0] dif5 = {1'b0, x1} - {1'b0, x2};
    wire [3:0] lv   = logic_fn(x3, x1, x2);
    wire       alu_oe = (alu_instr == 4'h7) || (alu_instr == 4'h8);
    assign bus = alu_oe ? ((alu_instr == 4'h7) ? r : flg) : 4'bzzzz;

    always @(posedge clk) begin
        case (alu_instr)
            4'h1: x1 <= bus;
            4'h2: x2 <= bus;
            4'h3: x3 <= bus;
            4'h4: begin r <= lv;         flg <= mk_flags(lv, 1'b0);               end
            4'h5: begin r <= sum5[3:0];  flg <= mk_flags(sum5[3:0], sum5[4]);     end
            4'h6: begin r <= dif5[3:0];  flg <= mk_flags(dif5[3:0], dif5[4]);     end
            4'h9: x1 <= r;
            4'hF: begin x1 <= 4'h0; x2 <= 4'h0; x3 <= 4'h0; r <= 4'h0; flg <= 4'h0; end
            default: ;
        endcase
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted response is compared with the queue head
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("rsp_result", 32'(rsp_result), 32'(exp_q[0].res));
                chk("rsp_flags",  32'(rsp_flags),  32'(exp_q[0].flg));
                chk("rsp_err",    32'(rsp_err),    32'(exp_q[0].err));
                void'(exp_q.pop_front());
            end
        end
    end

    // Issue one macro-op and check the step trace, bus operands and latency
    task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] sel, input logic [3:0] er, input logic [3:0] ef,
                         input logic ee, input int nst, input logic [23:0] trace, input int lat);
        int w;
        logic [3:0] code;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_sel = sel;
        @(posedge clk);
        exp_q.push_back({er, ef, ee});
        #1;
        req_valid = 1'b0; req_op = 3'd5; req_a = ~a; req_b = ~b; req_sel = ~sel;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k <= nst) begin
                code = trace[4*(k-1) +: 4];
                chk("alu_instr_step", 32'(alu_instr), 32'(code));
                chk("busy_step", 32'(busy), 32'd1);
                if (code == 4'h1) chk("bus_x1", 32'(bus), 32'(a));
                if (code == 4'h2) chk("bus_x2", 32'(bus), 32'(b));
                if (code == 4'h3) chk("bus_x3", 32'(bus), 32'(sel));
            end else begin
                chk("alu_instr_resp", 32'(alu_instr), 32'd0);
            end
            chk("rsp_valid_latency", 32'(rsp_valid), 32'(k == lat));
            if (k < lat) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // reset
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_alu_instr", 32'(alu_instr), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_result",    32'(rsp_result), 32'd0);
        chk("reset_flags",     32'(rsp_flags),  32'd0);
        chk("reset_err",       32'(rsp_err),    32'd0);
        @(posedge clk); #1;

        // ADD 4+1, SUB 4-1, then ACC +2 (req_a ignored)
        do_op(3'd0, 4'h4, 4'h1, 4'h0, 4'h5, 4'h0, 1'b0, 5, 24'h087521, 6);
        do_op(3'd1, 4'h4, 4'h1, 4'h0, 4'h3, 4'h0, 1'b0, 5, 24'h087621, 6);
        do_op(3'd3, 4'h9, 4'h2, 4'h0, 4'h5, 4'h0, 1'b0, 5, 24'h087529, 6);

        // LOGIC a=4 b=1 for every select
        for (int s = 1; s < 8; s++)
            do_op(3'd2, 4'h4, 4'h1, 4'(s), lres_tab[4*s +: 4], lflg_tab[4*s +: 4],
                  1'b0, 6, 24'h874321, 7);

        // carry and borrow boundaries
        do_op(3'd0, 4'hF, 4'h2, 4'h0, 4'h1, 4'h2, 1'b0, 5, 24'h087521, 6);
        do_op(3'd1, 4'h1, 4'h2, 4'h0, 4'hF, 4'h6, 1'b0, 5, 24'h087621, 6);

        // backpressure: ADD 2+3 held three cycles while a new request waits
        rsp_ready = 1'b0;
        do_op(3'd0, 4'h2, 4'h3, 4'h0, 4'h5, 4'h0, 1'b0, 5, 24'h087521, 6);
        req_valid = 1'b1; req_op = 3'd0; req_a = 4'h1; req_b = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result",    32'(rsp_result), 32'd5);
            chk("hold_flags",     32'(rsp_flags),  32'd0);
            chk("hold_req_ready", 32'(req_ready),  32'd0);
            chk("hold_alu_instr", 32'(alu_instr),  32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
        chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_busy",      32'(busy),      32'd0);
        @(posedge clk); #1;

        // reset while the ADD step (code 5) is on alu_instr
        req_valid = 1'b1; req_op = 3'd0; req_a = 4'h7; req_b = 4'h7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_alu_instr_add", 32'(alu_instr), 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_alu_instr", 32'(alu_instr), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        @(posedge clk); #1;
        do_op(3'd0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 1'b0, 5, 24'h087521, 6);

        // illegal ops, then CLEAR, then ACC from the cleared R
        do_op(3'd6, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1, 0, 24'h000000, 1);
        do_op(3'd7, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1, 0, 24'h000000, 1);
        do_op(3'd4, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 1, 24'h00000F, 2);
        do_op(3'd3, 4'h0, 4'h3, 4'h0, 4'h3, 4'h0, 1'b0, 5, 24'h087529, 6);

        // every scoreboard entry must have been matched by a response
        w = 0;
        while (exp_q.size() != 0 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
